ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. It consumes the ID/EX pipeline register outputs (control bits, D1/D2, immediate, Rs/Rt/Rd) and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- It contains the ALU, the ALUSrc and RegDst muxes, and the EX/MEM pipeline register.
- Its registered outputs feed the MEM stage directly.

---
 rtl/ex_stage.sv | 134 +++++++++++++
 tb/tb_ex_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU, ALUSrc/RegDst muxes and EX/MEM register
module ex_stage #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_flush_in,
   input  logic             wb_MemToReg_in,
   input  logic             wb_RegWrite_in,
   input  logic             MemRead_in,
   input  logic             MemWrite_in,
   input  logic             ex_ALUSrc_in,
   input  logic             ex_RegDst_in,
   input  logic [2:0]       ex_ALUOp_in,
   input  logic [WIDTH-1:0] D1_in,
   input  logic [WIDTH-1:0] D2_in,
   input  logic [WIDTH-1:0] immediate_in,
   input  logic [RADDR-1:0] Rs_in,
   input  logic [RADDR-1:0] Rt_in,
   input  logic [RADDR-1:0] Rd_in,
   input  logic             memwb_RegWrite,
   input  logic [RADDR-1:0] memwb_Rd,
   input  logic [WIDTH-1:0] memwb_data,
   output logic             wb_MemToReg_out,
   output logic             wb_RegWrite_out,
   output logic             MemRead_out,
   output logic             MemWrite_out,
   output logic [WIDTH-1:0] alu_result_out,
   output logic [WIDTH-1:0] store_data_out,
   output logic [RADDR-1:0] Rd_out,
   output logic             zero_out
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SLT = 3'b100,
      OP_XOR = 3'b101,
      OP_NOR = 3'b110,
      OP_PASSB = 3'b111
   } alu_op_e;

   logic             mem_to_reg_q, mem_to_reg_d;
   logic             reg_write_q, reg_write_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [WIDTH-1:0] alu_result_q, alu_result_d;
   logic [WIDTH-1:0] store_data_q, store_data_d;
   logic [RADDR-1:0] rd_q, rd_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_res;
   logic             exmem_hit_a, exmem_hit_b, memwb_hit_a, memwb_hit_b;

   // Register $0 never forwards; EX/MEM is younger than MEM/WB so it wins.
   always_comb begin
      exmem_hit_a = reg_write_q && (rd_q != '0) && (rd_q == Rs_in);
      exmem_hit_b = reg_write_q && (rd_q != '0) && (rd_q == Rt_in);
      memwb_hit_a = memwb_RegWrite && (memwb_Rd != '0) && (memwb_Rd == Rs_in);
      memwb_hit_b = memwb_RegWrite && (memwb_Rd != '0) && (memwb_Rd == Rt_in);

      fwd_a = D1_in;
      if (exmem_hit_a)      fwd_a = alu_result_q;
      else if (memwb_hit_a) fwd_a = memwb_data;

      fwd_b = D2_in;
      if (exmem_hit_b)      fwd_b = alu_result_q;
      else if (memwb_hit_b) fwd_b = memwb_data;

      op_b = ex_ALUSrc_in ? immediate_in : fwd_b;
   end

   always_comb begin
      alu_res = '0;
      case (alu_op_e'(ex_ALUOp_in))
         OP_ADD:   alu_res = fwd_a + op_b;
         OP_SUB:   alu_res = fwd_a - op_b;
         OP_AND:   alu_res = fwd_a & op_b;
         OP_OR:    alu_res = fwd_a | op_b;
         OP_SLT:   alu_res[0] = $signed(fwd_a) < $signed(op_b);
         OP_XOR:   alu_res = fwd_a ^ op_b;
         OP_NOR:   alu_res = ~(fwd_a | op_b);
         OP_PASSB: alu_res = op_b;
         default:  alu_res = '0;
      endcase
   end

   // A flush turns the instruction into a bubble by clearing only its control bits.
   always_comb begin
      mem_to_reg_d = wb_MemToReg_in && !if_flush_in;
      reg_write_d  = wb_RegWrite_in && !if_flush_in;
      mem_read_d   = MemRead_in && !if_flush_in;
      mem_write_d  = MemWrite_in && !if_flush_in;
      alu_result_d = alu_res;
      store_data_d = fwd_b;
      rd_d         = ex_RegDst_in ? Rd_in : Rt_in;
      zero_d       = (alu_res == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_result_q <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         zero_q       <= 1'b0;
      end else begin
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         zero_q       <= zero_d;
      end
   end

   assign wb_MemToReg_out = mem_to_reg_q;
   assign wb_RegWrite_out = reg_write_q;
   assign MemRead_out     = mem_read_q;
   assign MemWrite_out    = mem_write_q;
   assign alu_result_out  = alu_result_q;
   assign store_data_out  = store_data_q;
   assign Rd_out          = rd_q;
   assign zero_out        = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed-vector bench for ex_stage
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_flush_in;
   logic        wb_MemToReg_in, wb_RegWrite_in, MemRead_in, MemWrite_in;
   logic        ex_ALUSrc_in, ex_RegDst_in;
   logic [2:0]  ex_ALUOp_in;
   logic [31:0] D1_in, D2_in, immediate_in;
   logic [4:0]  Rs_in, Rt_in, Rd_in;
   logic        memwb_RegWrite;
   logic [4:0]  memwb_Rd;
   logic [31:0] memwb_data;
   logic        wb_MemToReg_out, wb_RegWrite_out, MemRead_out, MemWrite_out;
   logic [31:0] alu_result_out, store_data_out;
   logic [4:0]  Rd_out;
   logic        zero_out;

   int checks = 0;
   int errors = 0;

   ex_stage #(.WIDTH(32), .RADDR(5)) dut (
      .clk(clk), .rst(rst), .if_flush_in(if_flush_in),
      .wb_MemToReg_in(wb_MemToReg_in), .wb_RegWrite_in(wb_RegWrite_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .ex_ALUSrc_in(ex_ALUSrc_in), .ex_RegDst_in(ex_RegDst_in), .ex_ALUOp_in(ex_ALUOp_in),
      .D1_in(D1_in), .D2_in(D2_in), .immediate_in(immediate_in),
      .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
      .memwb_RegWrite(memwb_RegWrite), .memwb_Rd(memwb_Rd), .memwb_data(memwb_data),
      .wb_MemToReg_out(wb_MemToReg_out), .wb_RegWrite_out(wb_RegWrite_out),
      .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
      .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .Rd_out(Rd_out), .zero_out(zero_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, wb_MemToReg_out, wb_RegWrite_out, MemRead_out, MemWrite_out}, {28'd0, exp});
   endtask

   // Sets the datapath fields of one instruction; memory/flush/memwb controls are set by the caller.
   task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic src, input logic dst, input logic rw);
      ex_ALUOp_in    = op;
      D1_in          = d1;
      D2_in          = d2;
      immediate_in   = imm;
      Rs_in          = rs;
      Rt_in          = rt;
      Rd_in          = rd;
      ex_ALUSrc_in   = src;
      ex_RegDst_in   = dst;
      wb_RegWrite_in = rw;
      step();
   endtask

   initial begin
      // Reset with every input nonzero
      rst = 1'b1; if_flush_in = 1'b1;
      wb_MemToReg_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b1;
      memwb_RegWrite = 1'b1; memwb_Rd = 5'd9; memwb_data = 32'h55;
      issue(3'd0, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
      check_ctrl("reset_ctrl", 4'b0000);
      check("reset_alu", alu_result_out, 32'h0);
      check("reset_store", store_data_out, 32'h0);
      check("reset_rd", {27'd0, Rd_out}, 32'h0);
      check("reset_zero", {31'd0, zero_out}, 32'h0);

      rst = 1'b0; if_flush_in = 1'b0;
      wb_MemToReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
      memwb_RegWrite = 1'b0; memwb_Rd = 5'd0; memwb_data = 32'h0;

      issue(3'd0, 32'd5, 32'd7, 32'd0, 5'd1, 5'd6, 5'd3, 1'b0, 1'b1, 1'b1);
      check("add_alu", alu_result_out, 32'd12);
      check("add_rd", {27'd0, Rd_out}, 32'd3);
      check_ctrl("add_ctrl", 4'b0100);
      check("add_zero", {31'd0, zero_out}, 32'd0);

      issue(3'd1, 32'd0, 32'd0, 32'd1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
      check("sub_wrap", alu_result_out, 32'hFFFF_FFFF);

      issue(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd7, 5'd8, 5'd5, 1'b0, 1'b1, 1'b1);
      check("slt_signed", alu_result_out, 32'd1);

      // EX/MEM beats MEM/WB and stale D1
      issue(3'd0, 32'd4, 32'd6, 32'd0, 5'd9, 5'd10, 5'd4, 1'b0, 1'b1, 1'b1);
      check("fwd_setup", alu_result_out, 32'd10);
      memwb_RegWrite = 1'b1; memwb_Rd = 5'd4; memwb_data = 32'd50;
      issue(3'd1, 32'd99, 32'd3, 32'd0, 5'd4, 5'd11, 5'd12, 1'b0, 1'b1, 1'b1);
      check("fwd_exmem", alu_result_out, 32'd7);

      memwb_Rd = 5'd2; memwb_data = 32'd20;
      issue(3'd0, 32'd1, 32'd0, 32'd0, 5'd13, 5'd2, 5'd14, 1'b0, 1'b1, 1'b0);
      check("fwd_memwb", alu_result_out, 32'd21);

      memwb_Rd = 5'd0;
      issue(3'd0, 32'd1, 32'd0, 32'd0, 5'd13, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check("memwb_r0", alu_result_out, 32'd1);
      memwb_RegWrite = 1'b0;
      issue(3'd0, 32'd2, 32'd3, 32'd0, 5'd0, 5'd15, 5'd16, 1'b0, 1'b1, 1'b0);
      check("exmem_r0", alu_result_out, 32'd5);

      // Store data forwarded from EX/MEM
      issue(3'd7, 32'd0, 32'd0, 32'hAB, 5'd16, 5'd17, 5'd6, 1'b1, 1'b1, 1'b1);
      check("passb", alu_result_out, 32'hAB);
      MemWrite_in = 1'b1;
      issue(3'd0, 32'd100, 32'd0, 32'd8, 5'd18, 5'd6, 5'd30, 1'b1, 1'b0, 1'b0);
      check("store_addr", alu_result_out, 32'd108);
      check("store_data", store_data_out, 32'hAB);
      check("store_rd_rt", {27'd0, Rd_out}, 32'd6);
      check_ctrl("store_ctrl", 4'b0001);

      // Flush becomes a bubble and does not forward
      if_flush_in = 1'b1; wb_MemToReg_in = 1'b1; MemRead_in = 1'b1;
      issue(3'd0, 32'd30, 32'd40, 32'd0, 5'd19, 5'd20, 5'd21, 1'b0, 1'b1, 1'b1);
      check_ctrl("flush_ctrl", 4'b0000);
      check("flush_alu", alu_result_out, 32'd70);
      check("flush_rd", {27'd0, Rd_out}, 32'd21);
      if_flush_in = 1'b0; MemWrite_in = 1'b0;
      issue(3'd0, 32'd1, 32'd2, 32'd0, 5'd21, 5'd22, 5'd23, 1'b0, 1'b1, 1'b1);
      check("after_flush", alu_result_out, 32'd3);
      check_ctrl("load_ctrl", 4'b1110);
      wb_MemToReg_in = 1'b0; MemRead_in = 1'b0;

      issue(3'd1, 32'd9, 32'd9, 32'd0, 5'd24, 5'd25, 5'd1, 1'b0, 1'b1, 1'b0);
      check("sub_zero_alu", alu_result_out, 32'd0);
      check("sub_zero_flag", {31'd0, zero_out}, 32'd1);
      issue(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0);
      check("and", alu_result_out, 32'h0000_F000);
      issue(3'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0);
      check("or", alu_result_out, 32'h0000_FFF0);
      issue(3'd5, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0);
      check("xor", alu_result_out, 32'h0000_0FF0);
      issue(3'd6, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0);
      check("nor", alu_result_out, 32'hFFFF_FFFF);
      check("nor_zero_flag", {31'd0, zero_out}, 32'd0);

      // A flushed instruction still consumes the current EX/MEM value
      issue(3'd0, 32'd2, 32'd3, 32'd0, 5'd1, 5'd2, 5'd26, 1'b0, 1'b1, 1'b1);
      if_flush_in = 1'b1;
      issue(3'd0, 32'd0, 32'd1, 32'd0, 5'd26, 5'd27, 5'd28, 1'b0, 1'b1, 1'b1);
      check("flush_fwd_alu", alu_result_out, 32'd6);
      check_ctrl("flush_fwd_ctrl", 4'b0000);
      if_flush_in = 1'b0;

      // Mid-stream reset leaves no forwarding residue
      issue(3'd0, 32'd40, 32'd2, 32'd0, 5'd1, 5'd2, 5'd29, 1'b0, 1'b1, 1'b1);
      check("pre_reset", alu_result_out, 32'd42);
      rst = 1'b1;
      issue(3'd0, 32'd1, 32'd1, 32'd0, 5'd1, 5'd2, 5'd29, 1'b0, 1'b1, 1'b1);
      check("midreset_alu", alu_result_out, 32'd0);
      check_ctrl("midreset_ctrl", 4'b0000);
      rst = 1'b0;
      issue(3'd0, 32'd1, 32'd1, 32'd0, 5'd29, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
      check("post_reset", alu_result_out, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
